mdu: RTL and testbench
======================

MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy cycles for mult/multu (range 1..15).
REQ-002 Parameter DIV_CYCLES, default 10, busy cycles for div/divu (range 1..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 A  input  32  operand rs (E-stage forwarded value).
REQ-006 B  input  32  operand rt (E-stage forwarded value).
REQ-007 MDUOp  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7 treated as none.
REQ-008 start  input  1  one-cycle request qualifying MDUOp.
REQ-009 busy  output  1  operation in flight; the pipeline stalls D on md-class instructions while busy|start.
REQ-010 HI  output  32  HI register, driven directly from flop.
REQ-011 LO  output  32  LO register, driven directly from flop.

Function
REQ-012 States IDLE and BUSY; a 4-bit down-counter tracks remaining cycles.
REQ-013 IDLE, start=1, MDUOp in {1..4}: latch A, B and op; load counter with MULT_CYCLES or DIV_CYCLES; go BUSY next edge.
REQ-014 busy=1 exactly in BUSY; for a start in cycle N, busy is high cycles N+1..N+L (L = selected latency) and low in N+L+1.
REQ-015 HI/LO update on the edge ending cycle N+L; new values visible in cycle N+L+1, the same cycle busy falls.
REQ-016 HI/LO hold their old values throughout BUSY; the outputs never show partial results.
REQ-017 mult: signed 32x32 to 64 bits; HI = product[63:32], LO = product[31:0].
REQ-018 multu: same as mult, unsigned.
REQ-019 div: signed; LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
REQ-020 div 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0x00000000; no trap.
REQ-021 divu: unsigned quotient to LO, remainder to HI.
REQ-022 div/divu with B=0: counts its full latency with busy, then leaves HI/LO unchanged.
REQ-023 mthi/mtlo in IDLE with start=1: write A into HI or LO on that edge; busy stays 0.
REQ-024 start asserted while BUSY is ignored entirely (no restart, no mthi/mtlo write).
REQ-025 start=1 with MDUOp 0 or 7: no effect.
REQ-026 Operand changes on A/B during BUSY have no effect; latched operands are used.
REQ-027 Back-to-back: a start in the first cycle busy=0 after a completion is accepted normally.
REQ-028 A combinational 64-bit product and quotient may be used; a result is committed only at counter expiry.

Reset
REQ-029 rst=1 at an edge: state IDLE, counter 0, busy 0, HI 0, LO 0, latched operands 0.
REQ-030 rst overrides start in the same cycle; an operation in flight at reset is discarded and produces no HI/LO write.
REQ-031 Throughout an rst=1 cycle, busy reads 0 at the following edge.

Verification
REQ-032 Drive mult with A=0xFFFFFFFF, B=2 and start in cycle 0 -> busy is high in cycles 1-5; in cycle 6 HI=0xFFFFFFFF, LO=0xFFFFFFFE, busy=0.
REQ-033 Drive multu with A=0xFFFFFFFF, B=2 -> after 5 busy cycles HI=0x00000001, LO=0xFFFFFFFE.
REQ-034 Drive div with A=0xFFFFFFF9 (-7), B=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu with A=7, B=2 gives LO=3, HI=1.
REQ-035 First write HI=0x11, LO=0x22 via mthi/mtlo, then run divu with B=0 -> busy is high for 10 cycles; HI=0x11, LO=0x22 afterwards.
REQ-036 Start mult, then assert mtlo with start at busy cycle 2 -> mtlo is ignored and the mult result lands at cycle 6.
REQ-037 Start div, then assert rst at busy cycle 4 -> in the next cycle busy=0, HI=0, LO=0, and no later HI/LO update occurs.

Source files
------------

// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers: fixed-latency mult/div committed at counter expiry,
// single-cycle mthi/mtlo writes, and all requests ignored while an operation is in flight.
module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDUOp,
  input  logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  typedef enum logic {StIdle, StBusy} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q, hi_q, lo_q;

  logic        idle, accept_md, accept_mthi, accept_mtlo, is_mul_req, done;
  logic [63:0] mul_a, mul_b, prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, divisor, uquot, urem, quot, rem;

  always_comb begin
    idle        = (state_q == StIdle);
    is_mul_req  = (MDUOp == OpMult) || (MDUOp == OpMultu);
    accept_md   = idle && start && (MDUOp inside {OpMult, OpMultu, OpDiv, OpDivu});
    accept_mthi = idle && start && (MDUOp == OpMthi);
    accept_mtlo = idle && start && (MDUOp == OpMtlo);
    done        = (state_q == StBusy) && (cnt_q == 4'd1);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept_md) state_d = StBusy;
      StBusy: if (done)      state_d = StIdle;
      default:               state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == StBusy);
  end

  assign HI = hi_q;
  assign LO = lo_q;

  // Full-width product from the latched operands; sign- or zero-extended per op
  always_comb begin
    if (op_q == OpMult) begin
      mul_a = {{32{a_q[31]}}, a_q};
      mul_b = {{32{b_q[31]}}, b_q};
    end else begin
      mul_a = {32'd0, a_q};
      mul_b = {32'd0, b_q};
    end
    prod = mul_a * mul_b;
  end

  // Signed division via magnitudes; quotient truncates toward zero, remainder follows dividend.
  // A zero divisor is replaced so the divider never sees it; that result is never committed.
  always_comb begin
    a_neg   = (op_q == OpDiv) && a_q[31];
    b_neg   = (op_q == OpDiv) && b_q[31];
    a_mag   = a_neg ? (~a_q + 32'd1) : a_q;
    b_mag   = b_neg ? (~b_q + 32'd1) : b_q;
    divisor = (b_mag == 32'd0) ? 32'd1 : b_mag;
    uquot   = a_mag / divisor;
    urem    = a_mag % divisor;
    quot    = (a_neg ^ b_neg) ? (~uquot + 32'd1) : uquot;
    rem     = a_neg ? (~urem + 32'd1) : urem;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 4'd0;
      op_q  <= 3'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
    end else begin
      if (accept_md) begin
        a_q   <= A;
        b_q   <= B;
        op_q  <= MDUOp;
        cnt_q <= is_mul_req ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
      end else if (state_q == StBusy) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (accept_mthi) hi_q <= A;
      if (accept_mtlo) lo_q <= A;
      if (done) begin
        if ((op_q == OpMult) || (op_q == OpMultu)) begin
          hi_q <= prod[63:32];
          lo_q <= prod[31:0];
        end else if (b_q != 32'd0) begin
          hi_q <= rem;
          lo_q <= quot;
        end
      end
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: table of operations with hand-computed HI/LO and latency,
// plus sequences for requests during busy and reset mid-operation.
module tb_mdu;

  logic        clk;
  logic        rst;
  logic [31:0] A, B;
  logic [2:0]  MDUOp;
  logic        start;
  logic        busy;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;
  logic [31:0] prev_hi, prev_lo;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  mdu #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .B    (B),
    .MDUOp(MDUOp),
    .start(start),
    .busy (busy),
    .HI   (HI),
    .LO   (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Called just after a negedge; issues the request and walks its full latency.
  task automatic run_vec(input vec_t v, input int idx);
    A     = v.a;
    B     = v.b;
    MDUOp = v.op;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    MDUOp = 3'd0;
    for (int i = 1; i <= v.lat; i++) begin
      chk($sformatf("v%0d busy c%0d", idx, i), {31'd0, busy}, 32'd1);
      chk($sformatf("v%0d hi hold c%0d", idx, i), HI, prev_hi);
      chk($sformatf("v%0d lo hold c%0d", idx, i), LO, prev_lo);
      A = $urandom;
      B = $urandom;
      @(negedge clk);
    end
    chk($sformatf("v%0d busy end", idx), {31'd0, busy}, 32'd0);
    chk($sformatf("v%0d hi", idx), HI, v.exp_hi);
    chk($sformatf("v%0d lo", idx), LO, v.exp_lo);
    prev_hi = v.exp_hi;
    prev_lo = v.exp_lo;
  endtask

  initial begin
    vecs[0]  = '{3'd1, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 5};
    vecs[1]  = '{3'd2, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2]  = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3]  = '{3'd4, 32'd7,        32'd2,        32'h00000001, 32'h00000003, 10};
    vecs[4]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[5]  = '{3'd1, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 5};
    vecs[6]  = '{3'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[7]  = '{3'd2, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5};
    vecs[8]  = '{3'd4, 32'hFFFFFFFF, 32'd16,       32'h0000000F, 32'h0FFFFFFF, 10};
    vecs[9]  = '{3'd5, 32'h00000011, 32'd0,        32'h00000011, 32'h0FFFFFFF, 0};
    vecs[10] = '{3'd6, 32'h00000022, 32'd0,        32'h00000011, 32'h00000022, 0};
    vecs[11] = '{3'd4, 32'd5,        32'd0,        32'h00000011, 32'h00000022, 10};
    vecs[12] = '{3'd3, 32'hFFFFFFF0, 32'd0,        32'h00000011, 32'h00000022, 10};
    vecs[13] = '{3'd0, 32'h12345678, 32'd3,        32'h00000011, 32'h00000022, 0};
    vecs[14] = '{3'd7, 32'h12345678, 32'd3,        32'h00000011, 32'h00000022, 0};

    // Reset asserted together with an mthi request: reset must win
    rst   = 1'b1;
    start = 1'b1;
    MDUOp = 3'd5;
    A     = 32'h55;
    B     = 32'd0;
    @(negedge clk);
    @(negedge clk);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset hi", HI, 32'd0);
    chk("reset lo", LO, 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    MDUOp = 3'd0;
    @(negedge clk);
    prev_hi = 32'd0;
    prev_lo = 32'd0;

    // Back-to-back: each vector starts in the first idle cycle after the previous one
    for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

    // mult 3*5; mtlo attempted at busy cycle 2 must be ignored
    A = 32'd3; B = 32'd5; MDUOp = 3'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; MDUOp = 3'd0;
    for (int i = 1; i <= 5; i++) begin
      chk($sformatf("mtlo-in-busy busy c%0d", i), {31'd0, busy}, 32'd1);
      chk($sformatf("mtlo-in-busy lo hold c%0d", i), LO, 32'h22);
      if (i == 2) begin
        A = 32'hDEADBEEF; MDUOp = 3'd6; start = 1'b1;
      end else begin
        start = 1'b0; MDUOp = 3'd0;
      end
      @(negedge clk);
    end
    start = 1'b0; MDUOp = 3'd0;
    chk("mtlo-in-busy busy end", {31'd0, busy}, 32'd0);
    chk("mtlo-in-busy hi", HI, 32'd0);
    chk("mtlo-in-busy lo", LO, 32'd15);
    @(negedge clk);
    chk("mtlo-in-busy lo after", LO, 32'd15);

    // div 100/7 with reset during busy cycle 4
    A = 32'd100; B = 32'd7; MDUOp = 3'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0; MDUOp = 3'd0;
    for (int i = 1; i <= 3; i++) begin
      chk($sformatf("rst-mid busy c%0d", i), {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst-mid busy", {31'd0, busy}, 32'd0);
    chk("rst-mid hi", HI, 32'd0);
    chk("rst-mid lo", LO, 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk($sformatf("rst-mid idle c%0d", i), {31'd0, busy}, 32'd0);
      chk($sformatf("rst-mid hi c%0d", i), HI, 32'd0);
      chk($sformatf("rst-mid lo c%0d", i), LO, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
